// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCheck,
        StDone,
        StErr
    } state_e;

    localparam int unsigned CHECKSUM_W     = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 4;

    // States in which the loader is consuming frame bytes.
    function automatic logic is_busy(input state_e s);
        return (s == StLen) || (s == StData) || (s == StCheck);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler. word_valid and word are combinational
// on the byte that completes a word, so the caller can register the write
// on the same edge that accepts that byte.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      shift_q;
    logic             last;

    assign last       = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word_valid = byte_valid && last;
    // Newest byte lands in the top lane; earlier bytes shift toward bit 0.
    assign word       = {byte_data, shift_q[31:8]};

    // Byte counter and shift register; cleared when a new load starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid) begin
            shift_q <= word;
            cnt_q   <= last ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length/data/checksum byte frame from the host
// link and writes it into instruction memory while holding the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_flush,
    output logic        core_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                  state_q;
    logic [31:0]             len_q;
    logic [CHECKSUM_W-1:0]   sum_q;
    logic [CHECKSUM_W-1:0]   sum_next;
    logic [IDLE_W-1:0]       idle_q;
    logic                    busy;
    logic                    accept;
    logic                    start_ok;
    logic                    timeout_hit;
    logic                    pack_valid;
    logic                    word_valid;
    logic [31:0]             word;

    assign busy        = is_busy(state_q);
    assign accept      = in_valid && in_ready;
    assign start_ok    = start && !busy;
    assign sum_next    = sum_q + in_data;
    assign timeout_hit = !accept && ((32'(idle_q) + 32'd1) == TIMEOUT_CYCLES);
    // The length field is itself one little-endian word, so the packer serves both.
    assign pack_valid  = accept && ((state_q == StLen) || (state_q == StData));

    assign in_ready  = busy;
    // A failed image keeps the core parked until a successful reload.
    assign core_hold = busy || (state_q == StErr);

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_valid (pack_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Loader FSM with write port, status flags, checksum and idle timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            len_q        <= '0;
            sum_q        <= '0;
            idle_q       <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wd       <= '0;
            mem_flush    <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we    <= 1'b0;
            mem_flush <= 1'b0;
            if (start_ok) begin
                state_q      <= StLen;
                done         <= 1'b0;
                error        <= 1'b0;
                words_loaded <= '0;
                sum_q        <= '0;
                idle_q       <= '0;
            end else if (busy) begin
                if (accept) begin
                    idle_q <= '0;
                    sum_q  <= sum_next;
                end else begin
                    idle_q <= idle_q + 1'b1;
                end
                if (timeout_hit) begin
                    state_q <= StErr;
                    error   <= 1'b1;
                end else if (accept) begin
                    unique case (state_q)
                        StLen: begin
                            if (word_valid) begin
                                len_q <= word;
                                if (word > DEPTH_WORDS) begin
                                    state_q <= StErr;
                                    error   <= 1'b1;
                                end else if (word == 32'd0) begin
                                    state_q <= StCheck;
                                end else begin
                                    state_q <= StData;
                                end
                            end
                        end
                        StData: begin
                            if (word_valid) begin
                                mem_we       <= 1'b1;
                                mem_addr     <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                                mem_wd       <= word;
                                words_loaded <= words_loaded + 16'd1;
                                if ((32'(words_loaded) + 32'd1) == len_q) begin
                                    state_q <= StCheck;
                                end
                            end
                        end
                        StCheck: begin
                            if (sum_next == '0) begin
                                state_q   <= StDone;
                                done      <= 1'b1;
                                mem_flush <= 1'b1;
                            end else begin
                                state_q <= StErr;
                                error   <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that receives a byte stream from a host link and writes it, word by word, into the instruction memory write port. The host link uses a valid/ready handshake. While loading, the loader holds the core in reset. When the load completes, it flushes the instruction memory so the core fetches the new image from BASE_ADDR. It is the writer side of the instruction-memory interface: the core only ever reads that memory.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written
- DEPTH_WORDS, 1024, capacity of the instruction memory in 32-bit words
- TIMEOUT_CYCLES, 65535, maximum idle gap between accepted bytes while loading

Ports:
- clk  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored otherwise
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  loader accepts in_data this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  32  instruction memory byte address
- mem_wd  out  32  instruction memory write data
- mem_flush  out  1  one-cycle pulse invalidating the instruction memory read path
- core_hold  out  1  holds the core in reset while loading
- done  out  1  last load succeeded
- error  out  1  last load failed
- words_loaded  out  16  count of words written by the current or last load

## Operation
- States: IDLE, LEN, DATA, CHECK, DONE, ERR.
- A byte is accepted when in_valid and in_ready are both high.
- Frame format:
  - 4 length bytes, little-endian word count N;
  - then N words, 4 bytes each, little-endian;
  - then 1 checksum byte.
- Checksum rule:
  - sum (mod 256) of all length, data and checksum bytes must equal 8'h00;
  - the running sum is cleared on start.
- in_ready is 1 in LEN, DATA and CHECK, and 0 in IDLE, DONE and ERR.
- IDLE --start--> LEN. DONE --start--> LEN. ERR --start--> LEN.
  - start clears done, error, words_loaded, the byte counter and the checksum.
- LEN --4th byte--> next state depends on N:
  - N > DEPTH_WORDS: ERR;
  - N == 0: CHECK;
  - otherwise: DATA.
- DATA:
  - the 4th byte of each word triggers a write;
  - after word N-1 is written, the next state is CHECK.
- CHECK --byte--> DONE if the sum is 0, else ERR.
- Any busy state goes to ERR when the idle counter reaches TIMEOUT_CYCLES.
  - The counter resets on every accepted byte and on start.
- Write address for word k: BASE_ADDR + 4*k (32-bit wrap).
- words_loaded increments by 1 with every mem_we pulse.
- core_hold is 1 in LEN, DATA, CHECK and ERR, and 0 in IDLE and DONE.
  - A failed image never releases the core.
- done and error are sticky until the next start.
- start while in LEN, DATA or CHECK is ignored; there is no mid-load restart.

## Timing
- Reset (reset low, asynchronous) forces:
  - state IDLE;
  - in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wd=0, mem_flush=0;
  - core_hold=0, done=0, error=0, words_loaded=0.
- Reset mid-load abandons the frame with no further writes.
- Write latency: the 4th byte of a word is accepted at cycle T.
  - mem_we=1 for exactly cycle T+1, with mem_addr and mem_wd registered and stable in that cycle.
- Back-to-back bytes are accepted every cycle; there is no stall.
  - The minimum write spacing is 4 cycles.
- Entry to DONE at cycle T (the checksum byte was accepted at T-1):
  - mem_flush=1 in cycle T only;
  - core_hold drops to 0 in cycle T;
  - done rises to 1 in cycle T.
- ERR entry at cycle T: error=1 from cycle T, no flush pulse.
- Timeout: ERR is entered on the cycle the counter reaches TIMEOUT_CYCLES with no accepted byte.

## Structure
- Package imem_loader_pkg holds:
  - the state enum;
  - CHECKSUM_W=8;
  - BYTES_PER_WORD=4;
  - LEN_BYTES=4.
- Sub-module word_packer:
  - shifts in bytes little-endian;
  - raises word_valid for one cycle on the 4th byte;
  - clears on start.
- The loader FSM holds the address counter, words_loaded, the checksum accumulator and the timeout counter.

## Test plan
- Happy path: BASE_ADDR=0, frame 02 00 00 00, 13 00 00 00, 93 00 10 00, then checksum.
  - Expect mem_we twice: addr 0 with 32'h0000_0013, and addr 4 with 32'h0010_0093.
  - Then flush pulse, done=1, core_hold=0, words_loaded=2.
- Zero-length frame 00 00 00 00 00: no mem_we, DONE with one flush pulse.
- Bad checksum (happy-path frame with the last byte +1): ERR, error=1, core_hold stays 1, no flush.
- Oversize: N=DEPTH_WORDS+1 goes to ERR right after the 4th length byte, and in_ready drops the next cycle.
- Timeout with TIMEOUT_CYCLES=16: stop in_valid after 2 data bytes.
  - ERR after 16 idle cycles, words_loaded unchanged.
  - Then start plus a valid frame recovers to DONE.
- Reset asserted between data bytes: all outputs return to reset values immediately, and no further mem_we.
